// File: rtl/pellet_pkg.sv
// pellet_pkg: screen geometry, coordinate widths, dummy coordinates and FSM encoding
// shared by pellet_spawner and pellet_datapath.
package pellet_pkg;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int X_MAX_DEF = 160;
  localparam int Y_MAX_DEF = 120;
  localparam logic [XW-1:0] X_DUMMY = 8'hFF;
  localparam logic [YW-1:0] Y_DUMMY = 7'h7F;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11); a zero seed is replaced by 1
// since the all-zero state would lock up.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  output logic [15:0] state
);
  localparam logic [15:0] SEED_L = (SEED == 16'h0) ? 16'h0001 : SEED;
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = en ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
  always_ff @(posedge clock) lfsr_q <= !reset_n ? SEED_L : lfsr_d;
  assign state = lfsr_q;
endmodule

// File: rtl/pellet_spawner.sv
// pellet_spawner: draws random candidates, feeds pellet_datapath and retries until a
// legal cell off Pac-Man is found or the retry budget runs out.
module pellet_spawner
  import pellet_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int MAX_TRIES = 64,
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          spawn_req,
  input  logic [XW-1:0] pac_x,
  input  logic [YW-1:0] pac_y,
  output logic          new_coord,
  output logic [XW-1:0] rand_x,
  output logic [YW-1:0] rand_y,
  input  logic          valid_coord,
  input  logic [XW-1:0] dp_x,
  input  logic [YW-1:0] dp_y,
  output logic [XW-1:0] pellet_x,
  output logic [YW-1:0] pellet_y,
  output logic          pellet_valid,
  output logic          fail,
  output logic          busy
);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [XW-1:0] XL = XW'(X_MAX);
  localparam logic [YW-1:0] YL = YW'(Y_MAX);
  localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);
  logic [15:0] lfsr;
  logic [XW-1:0] cx, rand_x_q, rand_x_d, pellet_x_q, pellet_x_d;
  logic [YW-1:0] cy, rand_y_q, rand_y_d, pellet_y_q, pellet_y_d;
  logic [2:0] state_q, state_d;
  logic [TW-1:0] tries_q, tries_d;
  logic new_coord_q, pellet_valid_q, fail_q, busy_q, accept;
  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (1'b1),
    .state  (lfsr)
  );
  assign cx = (lfsr[7:0] >= XL) ? lfsr[7:0] - XL : lfsr[7:0];
  assign cy = (lfsr[15:9] >= YL) ? lfsr[15:9] - YL : lfsr[15:9];
  assign accept = valid_coord && !(dp_x == pac_x && dp_y == pac_y);
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    rand_x_d = rand_x_q;
    rand_y_d = rand_y_q;
    pellet_x_d = pellet_x_q;
    pellet_y_d = pellet_y_q;
    case (state_q)
      S_IDLE: if (spawn_req) begin
        state_d = S_ISSUE;
        tries_d = '0;
        rand_x_d = cx;
        rand_y_d = cy;
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: if (accept) begin
        state_d = S_DONE;
        pellet_x_d = dp_x;
        pellet_y_d = dp_y;
      end else if (tries_q == LAST) begin
        state_d = S_FAIL;
      end else begin
        state_d = S_ISSUE;
        tries_d = tries_q + TW'(1);
        rand_x_d = cx;
        rand_y_d = cy;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Status outputs are registered copies decoded from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tries_q <= '0;
      rand_x_q <= X_DUMMY;
      rand_y_q <= Y_DUMMY;
      pellet_x_q <= X_DUMMY;
      pellet_y_q <= Y_DUMMY;
      new_coord_q <= 1'b0;
      pellet_valid_q <= 1'b0;
      fail_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      rand_x_q <= rand_x_d;
      rand_y_q <= rand_y_d;
      pellet_x_q <= pellet_x_d;
      pellet_y_q <= pellet_y_d;
      new_coord_q <= state_d == S_ISSUE;
      pellet_valid_q <= state_d == S_DONE;
      fail_q <= state_d == S_FAIL;
      busy_q <= state_d == S_ISSUE || state_d == S_CHECK;
    end
  end
  assign new_coord = new_coord_q;
  assign rand_x = rand_x_q;
  assign rand_y = rand_y_q;
  assign pellet_x = pellet_x_q;
  assign pellet_y = pellet_y_q;
  assign pellet_valid = pellet_valid_q;
  assign fail = fail_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_pellet_spawner.sv
// tb_pellet_spawner: directed checks of pellet_spawner (MAX_TRIES=4) against a reference
// LFSR and a registering pellet_datapath model.
module tb_pellet_spawner;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic spawn_req = 1'b0;
  logic [7:0] pac_x = '0;
  logic [6:0] pac_y = '0;
  logic new_coord, valid_coord, pellet_valid, fail, busy;
  logic [7:0] rand_x, pellet_x, dp_x;
  logic [6:0] rand_y, pellet_y, dp_y;
  logic [15:0] lfsr_m;
  int issued = 0;
  int base = 0;
  int rej = 0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  pellet_spawner #(.MAX_TRIES(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .spawn_req   (spawn_req),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .new_coord   (new_coord),
    .rand_x      (rand_x),
    .rand_y      (rand_y),
    .valid_coord (valid_coord),
    .dp_x        (dp_x),
    .dp_y        (dp_y),
    .pellet_x    (pellet_x),
    .pellet_y    (pellet_y),
    .pellet_valid(pellet_valid),
    .fail        (fail),
    .busy        (busy)
  );
  always @(posedge clock) lfsr_m <= !reset_n ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  always @(posedge clock) begin
    if (!reset_n) begin
      dp_x <= 8'hFF;
      dp_y <= 7'h7F;
    end else if (new_coord) begin
      dp_x <= rand_x;
      dp_y <= rand_y;
    end
    if (new_coord) issued <= issued + 1;
  end
  assign valid_coord = (issued - base) > rej;
  function automatic logic [7:0] fx(input logic [15:0] l);
    return (l[7:0] >= 8'd160) ? l[7:0] - 8'd160 : l[7:0];
  endfunction
  function automatic logic [6:0] fy(input logic [15:0] l);
    return (l[15:9] >= 7'd120) ? l[15:9] - 7'd120 : l[15:9];
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int r, input int len, input int hold, input bit collide, input int rst_c,
                     output logic [31:0] nc, output logic [31:0] pv, output logic [31:0] fl,
                     output logic [31:0] bz, output logic [7:0] lx, output logic [6:0] ly);
    logic [15:0] p;
    nc = '0;
    pv = '0;
    fl = '0;
    bz = '0;
    lx = 8'hFF;
    ly = 7'h7F;
    rej = r;
    base = issued;
    @(negedge clock);
    spawn_req = 1'b1;
    if (collide) begin
      pac_x = fx(lfsr_m);
      pac_y = fy(lfsr_m);
    end
    for (int c = 1; c <= len; c++) begin
      p = lfsr_m;
      @(negedge clock);
      nc[c] = new_coord;
      pv[c] = pellet_valid;
      fl[c] = fail;
      bz[c] = busy;
      if (new_coord) begin
        check("cand_x", rand_x, fx(p));
        check("cand_y", rand_y, fy(p));
        lx = rand_x;
        ly = rand_y;
      end
      spawn_req = c < hold;
      reset_n = c != rst_c;
      if (c == 3) begin
        pac_x = '0;
        pac_y = '0;
      end
    end
  endtask
  initial begin
    logic [31:0] nc, pv, fl, bz;
    logic [7:0] lx;
    logic [6:0] ly;
    int pv_cnt;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    nc = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      nc[c] = new_coord;
    end
    check("rst_nc", nc, 0);
    check("rst_rx", rand_x, 8'hFF);
    check("rst_ry", rand_y, 7'h7F);
    check("rst_px", pellet_x, 8'hFF);
    check("rst_py", pellet_y, 7'h7F);
    check("rst_pv", pellet_valid, 0);
    check("rst_fail", fail, 0);
    check("rst_busy", busy, 0);
    run(99, 11, 1, 0, -1, nc, pv, fl, bz, lx, ly);
    check("exh_nc", nc, 32'hAA);
    check("exh_fail", fl, 32'h200);
    check("exh_pv", pv, 0);
    check("exh_busy", bz, 32'h1FE);
    check("exh_px", pellet_x, 8'hFF);
    check("exh_py", pellet_y, 7'h7F);
    run(0, 6, 1, 0, -1, nc, pv, fl, bz, lx, ly);
    check("imm_nc", nc, 32'h2);
    check("imm_pv", pv, 32'h8);
    check("imm_fail", fl, 0);
    check("imm_busy", bz, 32'h6);
    check("imm_px", pellet_x, lx);
    check("imm_py", pellet_y, ly);
    run(3, 12, 1, 0, -1, nc, pv, fl, bz, lx, ly);
    check("map_nc", nc, 32'hAA);
    check("map_pv", pv, 32'h200);
    check("map_fail", fl, 0);
    check("map_busy", bz, 32'h1FE);
    check("map_px", pellet_x, lx);
    check("map_py", pellet_y, ly);
    run(0, 8, 1, 1, -1, nc, pv, fl, bz, lx, ly);
    check("pac_nc", nc, 32'hA);
    check("pac_pv", pv, 32'h20);
    check("pac_busy", bz, 32'h1E);
    check("pac_px", pellet_x, lx);
    check("pac_py", pellet_y, ly);
    run(0, 10, 4, 0, -1, nc, pv, fl, bz, lx, ly);
    check("hold_nc", nc, 32'h2);
    check("hold_pv", pv, 32'h8);
    check("hold_busy", bz, 32'h6);
    run(0, 6, 1, 0, 2, nc, pv, fl, bz, lx, ly);
    check("rmid_nc", nc, 32'h2);
    check("rmid_pv", pv, 0);
    check("rmid_fail", fl, 0);
    check("rmid_busy", bz, 32'h6);
    check("rmid_px", pellet_x, 8'hFF);
    rej = 0;
    base = issued;
    pv_cnt = 0;
    @(negedge clock);
    spawn_req = 1'b1;
    for (int c = 0; c < 8000 && pv_cnt < 1000; c++) begin
      @(negedge clock);
      if (new_coord) check("range", {30'd0, rand_x < 8'd160, rand_y < 7'd120}, 32'h3);
      if (pellet_valid) pv_cnt++;
    end
    spawn_req = 1'b0;
    check("range_cnt", 32'(pv_cnt), 32'd1000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pellet_spawner.md
# pellet_spawner

Pellet spawn controller sitting directly upstream of `pellet_datapath`. It generates pseudo-random candidate screen coordinates with an LFSR, range-reduces them to the 160×120 playfield, and strobes them into `pellet_datapath`. It then checks the returned map validity and rejects candidates on Pac-Man's current cell, retrying until a legal pellet is found or a retry budget is exhausted. Game logic requests a pellet with a single pulse and receives either a `pellet_valid` or a `fail` pulse.

## Interface
- `SEED`, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'h0001.
- `MAX_TRIES`, 64, candidate attempts per request before `fail` (≥1).
- `X_MAX`, 160, exclusive upper bound for x.
- `Y_MAX`, 120, exclusive upper bound for y.

- `clock` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `spawn_req` in 1: request pulse; sampled only in IDLE.
- `pac_x` in 8 / `pac_y` in 7: Pac-Man cell; a candidate equal to it is rejected.
- `new_coord` out 1: load strobe to `pellet_datapath`.
- `rand_x` out 8 / `rand_y` out 7: candidate to `pellet_datapath`; registered.
- `valid_coord` in 1: map legality from `pellet_datapath`.
- `dp_x` in 8 / `dp_y` in 7: `pellet_datapath` `x_out`/`y_out`.
- `pellet_x` out 8 / `pellet_y` out 7: last accepted pellet; held between requests.
- `pellet_valid` out 1: one-cycle pulse when a new pellet is accepted.
- `fail` out 1: one-cycle pulse when the retry budget is exhausted.
- `busy` out 1: high in ISSUE and CHECK.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, advances every cycle after reset (free-running), next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- **Candidate reduction:**
  - cx = lfsr[7:0]; if cx ≥ X_MAX then cx − X_MAX.
  - cy = lfsr[15:9]; if cy ≥ Y_MAX then cy − Y_MAX.
  - Single subtract; the result is always in range for the defaults.
- **States:** IDLE, ISSUE, CHECK, DONE, FAIL.
- **IDLE:**
  - On `spawn_req`: load rand_x/rand_y ← cx/cy, tries ← 0, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:** `new_coord`=1 for exactly this cycle; rand_x/rand_y stable. Go to CHECK.
- **CHECK:** `pellet_datapath` has registered the candidate. Accept if `valid_coord` && !(dp_x==pac_x && dp_y==pac_y).
  - Accept: pellet_x/pellet_y ← dp_x/dp_y, go to DONE.
  - Reject and tries == MAX_TRIES−1: go to FAIL.
  - Reject otherwise: tries++, rand_x/rand_y ← fresh cx/cy, go to ISSUE.
- **DONE:** `pellet_valid`=1, then IDLE.
- **FAIL:** `fail`=1, then IDLE. pellet_x/pellet_y keep their previous value.
- **`spawn_req` outside IDLE:** ignored; no queueing, including in the DONE and FAIL cycles.
- **pac_x/pac_y:** sampled only in CHECK; changes elsewhere are irrelevant.
- **Tries counter:** width $clog2(MAX_TRIES).

## Timing
- **Reset values:** state=IDLE, lfsr=SEED, new_coord=0, rand_x=8'hFF, rand_y=7'h7F, pellet_x=8'hFF, pellet_y=7'h7F, pellet_valid=0, fail=0, busy=0, tries=0.
- **Request latency:** `spawn_req` high in cycle 0 gives `new_coord` in cycle 1, CHECK in cycle 2, and `pellet_valid` in cycle 3 (minimum).
- **Retries:** each rejection adds 2 cycles. Accept on attempt k gives `pellet_valid` at cycle 2k+1.
- **Budget exhausted:** `fail` at cycle 2·MAX_TRIES+1.
- **Outputs:** all registered; no combinational input-to-output paths.
- **Reset mid-operation:** any state goes to IDLE on the next edge. An in-flight attempt is dropped with no pulse.
- **Next request:** the earliest new request is accepted in the cycle after DONE/FAIL.

## Structure
- **Shared package `pellet_pkg`:**
  - state encoding (3-bit);
  - X_MAX/Y_MAX screen constants;
  - coordinate widths (8/7);
  - dummy reset coordinates 8'hFF/7'h7F, shared with `pellet_datapath`.
- **Sub-module `lfsr16`:** seed parameter, enable, 16-bit state output. The range reduction stays in `pellet_spawner`.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles, then idle 10 cycles → all outputs at reset values; `new_coord` never asserted; LFSR sequence from 16'hACE1 matches the reference model.
- **Immediate accept:** bench datapath model registers on `new_coord` and drives valid_coord=1; pac=(0,0) and never equal to the candidate. Pulse `spawn_req` at cycle 0 → `new_coord` only in cycle 1; `pellet_valid` in cycle 3; pellet_x/pellet_y equal the rand_x/rand_y issued in cycle 1.
- **Map retries:** valid_coord=0 for the first 3 attempts → `new_coord` in cycles 1, 3, 5, 7; `pellet_valid` in cycle 9; the 4th candidate is accepted.
- **Pac-Man collision:** drive pac_x/pac_y equal to dp_x/dp_y on the first CHECK with valid_coord=1 → rejected, second attempt issued; accept in cycle 5.
- **Exhaustion:** MAX_TRIES=4, valid_coord always 0 → 4 `new_coord` pulses; `fail` in cycle 9; pellet_x/pellet_y unchanged (8'hFF/7'h7F); busy=0 in cycle 9.
- **Range and robustness:** 1000 back-to-back requests → rand_x<160 and rand_y<120 always. `spawn_req` held high during busy causes no extra pulses. reset_n=0 during CHECK gives IDLE next cycle with no `pellet_valid` or `fail`.
